// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder: start/busy/done handshake,
// operands in, registered result out.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first.
// {cout, sum} = a + b + cin after WIDTH RUN cycles; result held between ops.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_ps;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_ps_next;

    // Full-adder cell on the current LSBs and the running carry.
    assign w_s       = r_sa[0] ^ r_sb[0] ^ r_c;
    assign w_c       = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_ps_next = {w_s, r_ps[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_ps   <= '0;
            r_sum  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sa  <= bus.a;
                        r_sb  <= bus.b;
                        r_c   <= bus.cin;
                        r_cnt <= '0;
                        r_ps  <= '0;
                    end
                end
                S_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_ps  <= w_ps_next;
                    r_c   <= w_c;
                    r_cnt <= r_cnt + CW'(1);
                    // Result registers only move on the final bit so they hold the last answer during RUN.
                    if (w_last) begin
                        r_sum  <= w_ps_next;
                        r_cout <= w_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Directed and random bench for serial_adder: a scoreboard queue holds the
// expected {cout,sum} for each issued operation and is popped on every done pulse.
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic clk_en;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    logic [W:0] q[$];

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            check("done_has_expected", 64'(q.size() != 0), 64'd1);
            check("busy_low_at_done", 64'(bus.busy), 64'd0);
            if (q.size() != 0) begin
                logic [W:0] exp;
                exp = q.pop_front();
                check("result", 64'({bus.cout, bus.sum}), 64'(exp));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.start = 1'b1;
        q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check("done_timeout", 64'(seen), 64'd1);
    endtask

    task automatic set_rand();
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.cin = 1'($urandom);
        q.push_back({1'b0, bus.a} + {1'b0, bus.b} + {{W{1'b0}}, bus.cin});
    endtask

    initial begin
        int dones;
        int accepts;
        int prev_acc;
        bit pb;
        bit found;

        checks    = 0;
        errors    = 0;
        clk_en    = 1'b0;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        // Reset with the clock stopped must clear outputs immediately.
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_sum", 64'(bus.sum), 64'd0);
        check("rst_cout", 64'(bus.cout), 64'd0);
        #4 rst_n = 1'b1;
        clk_en = 1'b1;

        // Basic add with busy/done cycle timing.
        issue(8'h3C, 8'h05, 1'b0);
        dones = 0;
        for (int i = 0; i < W; i++) begin
            check("basic_busy", 64'(bus.busy), 64'd1);
            check("basic_hold_sum", 64'(bus.sum), 64'd0);
            @(negedge clk);
        end
        check("basic_done", 64'(bus.done), 64'd1);
        check("basic_sum", 64'(bus.sum), 64'h41);
        @(negedge clk);
        check("basic_done_pulse", 64'(bus.done), 64'd0);
        check("basic_idle_busy", 64'(bus.busy), 64'd0);

        issue(8'hFF, 8'h01, 1'b0);
        wait_done();
        check("ovf_sum", 64'({bus.cout, bus.sum}), 64'h100);
        issue(8'h00, 8'h00, 1'b1);
        wait_done();
        check("cin_sum", 64'({bus.cout, bus.sum}), 64'h001);
        issue(8'hFF, 8'hFF, 1'b1);
        wait_done();
        check("max_sum", 64'({bus.cout, bus.sum}), 64'h1FF);

        // start during RUN (sampled at E3) and in DONE must be ignored.
        issue(8'h20, 8'h13, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.a     = 8'h11;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("ignored_start_dones", 64'(dones), 64'd0);
        check("ignored_start_sum", 64'({bus.cout, bus.sum}), 64'h033);

        // Reset after E4 aborts the operation and clears the result.
        @(negedge clk);
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_sum", 64'(bus.sum), 64'd0);
        check("midrst_cout", 64'(bus.cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h01, 8'h02, 1'b0);
        wait_done();
        check("post_rst_sum", 64'({bus.cout, bus.sum}), 64'h003);

        // start held high: accepts every W+2 cycles, fresh random operands each time.
        @(negedge clk);
        set_rand();
        bus.start = 1'b1;
        pb        = 1'b0;
        accepts   = 0;
        prev_acc  = 0;
        while (accepts < 1000) begin
            found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (bus.busy === 1'b1 && !pb) found = 1'b1;
                pb = (bus.busy === 1'b1);
            end
            check("accept_timeout", 64'(found), 64'd1);
            if (!found) break;
            if (accepts > 0) check("accept_gap", 64'(cyc - prev_acc), 64'(W + 2));
            prev_acc = cyc;
            accepts++;
            if (accepts < 1000) set_rand();
            else bus.start = 1'b0;
        end
        bus.start = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
